// File: rtl/read_addr_gen.sv
// Read-side frame address generator for the 4-buffer DRAM frame ring.
// Latency: addr_valid rises 1 cycle after start is accepted (or after wr_done in WAIT); frame_done 1 cycle after the last beat.
// Backpressure: addr/cnt hold while addr_ready is low; one address per cycle at full throughput.
//
// Ports:
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   wr_done, wr_sel      writer finished buffer wr_sel (single-cycle pulse)
//   start                request one frame read (sampled in IDLE only)
//   addr, addr_valid     byte address stream to the read DMA
//   addr_ready           DMA accepts addr this cycle
//   rd_sel               buffer being read, or the last one read
//   busy                 waiting for a frame or streaming one
//   frame_done           one-cycle pulse after the last word is accepted
//   overrun              sticky: writer lapped the buffer being read
module read_addr_gen #(
    parameter logic [31:0] BASE0           = 32'h0F80_0000,
    parameter logic [31:0] BASE1           = 32'h0FC0_0000,
    parameter logic [31:0] BASE2           = 32'h1000_0000,
    parameter logic [31:0] BASE3           = 32'h1040_0000,
    parameter logic [23:0] WORDS_PER_FRAME = 24'd4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        wr_done,
    input  logic [1:0]  wr_sel,
    input  logic        start,
    output logic [31:0] addr,
    output logic        addr_valid,
    input  logic        addr_ready,
    output logic [1:0]  rd_sel,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [23:0] LAST_CNT = WORDS_PER_FRAME - 24'd1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Most recently completed buffer; stays valid once seen so a frame can be re-read.
    logic [1:0]  latest;
    logic        latest_valid;
    logic [23:0] cnt;

    // Control strobes decoded from the current state and inputs.
    logic        start_acc;
    logic        stream_load;
    logic [1:0]  load_sel;
    logic [31:0] load_base;
    logic        beat;
    logic        last_beat;
    logic [1:0]  rd_prev;
    logic        ovr_hit;

    function automatic logic [31:0] base_of(input logic [1:0] sel);
        logic [31:0] b;
        case (sel)
            2'd0:    b = BASE0;
            2'd1:    b = BASE1;
            2'd2:    b = BASE2;
            default: b = BASE3;
        endcase
        return b;
    endfunction

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A frame finishing this very cycle counts as available.
                    if (wr_done || latest_valid) begin
                        state_nxt = S_STREAM;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (addr_ready && (cnt == LAST_CNT)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/strobe decode.
    always_comb begin
        start_acc   = 1'b0;
        stream_load = 1'b0;
        load_sel    = latest;
        beat        = 1'b0;
        last_beat   = 1'b0;
        ovr_hit     = 1'b0;
        rd_prev     = rd_sel - 2'd1;

        case (state)
            S_IDLE: begin
                start_acc = start;
                if (start && (wr_done || latest_valid)) begin
                    stream_load = 1'b1;
                    // wr_sel from the same cycle is newer than the registered latest.
                    load_sel    = wr_done ? wr_sel : latest;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    stream_load = 1'b1;
                    load_sel    = wr_sel;
                end
            end
            S_STREAM: begin
                // addr_valid is always high in STREAM, so ready alone marks a beat.
                beat      = addr_ready;
                last_beat = addr_ready && (cnt == LAST_CNT);
                // Writer now owns rd_sel (finished the one before it) or just rewrote it.
                ovr_hit   = wr_done && ((wr_sel == rd_prev) || (wr_sel == rd_sel));
            end
            default: ;
        endcase

        load_base = base_of(load_sel);
    end

    // Datapath and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            latest       <= 2'd0;
            latest_valid <= 1'b0;
            cnt          <= 24'd0;
            addr         <= BASE0;
            addr_valid   <= 1'b0;
            rd_sel       <= 2'd0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (wr_done) begin
                latest       <= wr_sel;
                latest_valid <= 1'b1;
            end

            busy       <= (state_nxt != S_IDLE);
            addr_valid <= (state_nxt == S_STREAM);
            frame_done <= last_beat;

            if (stream_load) begin
                rd_sel <= load_sel;
                addr   <= load_base;
                cnt    <= 24'd0;
            end else if (beat && !last_beat) begin
                addr <= addr + 32'd4;
                cnt  <= cnt + 24'd1;
            end
            // On the last beat addr keeps the final word address.

            // start_acc and ovr_hit are mutually exclusive (IDLE vs STREAM).
            if (start_acc) begin
                overrun <= 1'b0;
            end else if (ovr_hit) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
